// File: rtl/stage_mem_lsu.sv
// MEM-stage load/store unit: address-aware byte-lane steering, load
// sign/zero extension and a req/gnt/rvalid data-memory handshake with timeout.
module stage_mem_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_i_valid,
  input  logic [1:0]          mem_i_is_ls,
  input  logic [1:0]          mem_i_width,
  input  logic                mem_i_unsigned,
  input  logic [ADDR_W-1:0]   mem_i_addr,
  input  logic [DATA_W-1:0]   mem_i_wdata,
  output logic                mem_o_stall,
  output logic                mem_o_done,
  output logic [DATA_W-1:0]   mem_o_rdata,
  output logic                mem_o_misalign,
  output logic                mem_o_buserr,
  output logic                dm_req,
  output logic                dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic                dm_gnt,
  input  logic                dm_rvalid,
  input  logic [DATA_W-1:0]   dm_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                we_q;
  logic                uns_q;
  logic [1:0]          width_q;
  logic [OFS_W-1:0]    ofs_q;

  logic                is_ld, is_st, aligned, width_ok, accept, go;
  logic [OFS_W-1:0]    ofs;
  logic [3:0]          size;
  logic [2:0]          amask;
  int unsigned         ofs_n, size_n, nbits;
  logic [NB-1:0]       be_nx;
  logic [DATA_W-1:0]   wdata_sh;
  logic [DATA_W-1:0]   rd_sh;
  logic [DATA_W-1:0]   rd_ext;
  logic                sign_b;
  logic                timed_out;

  // Request decode, alignment check and store lane steering
  always_comb begin
    is_ld    = (mem_i_is_ls == 2'd1);
    is_st    = (mem_i_is_ls == 2'd2);
    ofs      = mem_i_addr[OFS_W-1:0];
    size     = 4'd1 << mem_i_width;
    // size-1 in 3 bits; size 8 wraps to 0-1 = 3'b111, the correct DWORD mask
    amask    = size[2:0] - 3'd1;
    aligned  = ((mem_i_addr[2:0] & amask) == 3'd0);
    width_ok = (mem_i_width != 2'd3) || (DATA_W == 64);
    accept   = !rst && (state == S_IDLE) && mem_i_valid && (is_ld || is_st);
    go       = accept && aligned && width_ok;
    ofs_n    = 32'(ofs);
    size_n   = 32'(size);
    be_nx    = '0;
    for (int unsigned i = 0; i < NB; i++)
      be_nx[i] = (i >= ofs_n) && (i < ofs_n + size_n);
    wdata_sh = mem_i_wdata << {ofs, 3'b000};
  end

  // Load alignment and sign/zero extension from the latched offset and width
  always_comb begin
    rd_sh = dm_rdata >> {ofs_q, 3'b000};
    nbits = 32'd8 << width_q;
    case (width_q)
      2'd0:    sign_b = rd_sh[7];
      2'd1:    sign_b = rd_sh[15];
      2'd2:    sign_b = rd_sh[31];
      default: sign_b = rd_sh[DATA_W-1];
    endcase
    rd_ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++)
      rd_ext[i] = (i < nbits) ? rd_sh[i] : (!uns_q && sign_b);
  end

  // Next-state logic
  always_comb begin
    state_nx  = state;
    timed_out = (cnt == CNT_W'(TIMEOUT - 1));
    case (state)
      S_IDLE: if (go) state_nx = S_REQ;
      S_REQ: begin
        if (dm_gnt)         state_nx = we_q ? S_DONE : S_WAIT;
        else if (timed_out) state_nx = S_ERR;
      end
      S_WAIT: begin
        if (dm_rvalid)      state_nx = S_DONE;
        else if (timed_out) state_nx = S_ERR;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Timeout counter: restarts on entry to REQ/WAIT, counts cycles without the event
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if ((state_nx != state) && ((state_nx == S_REQ) || (state_nx == S_WAIT)))
      cnt <= '0;
    else if (((state == S_REQ) && !dm_gnt) || ((state == S_WAIT) && !dm_rvalid))
      cnt <= cnt + 1'b1;
  end

  // Latched request fields and registered load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      width_q <= '0;
      ofs_q   <= '0;
      rdata_q <= '0;
    end else if (go) begin
      addr_q  <= {mem_i_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      be_q    <= be_nx;
      wdata_q <= wdata_sh;
      we_q    <= is_st;
      uns_q   <= mem_i_unsigned;
      width_q <= mem_i_width;
      ofs_q   <= ofs;
      rdata_q <= '0;
    end else if ((state == S_WAIT) && dm_rvalid) begin
      rdata_q <= rd_ext;
    end
  end

  // Output decode
  always_comb begin
    mem_o_stall    = go || (state == S_REQ) || (state == S_WAIT);
    mem_o_misalign = accept && !(aligned && width_ok);
    mem_o_done     = (state == S_DONE);
    mem_o_buserr   = (state == S_ERR);
    mem_o_rdata    = rdata_q;
    dm_req         = (state == S_REQ);
    dm_we          = dm_req && we_q;
    dm_addr        = addr_q;
    dm_be          = be_q;
    dm_wdata       = wdata_q;
  end

endmodule
